// File: rtl/linear_fc_engine.sv
// linear_fc_engine: fully-connected layer, y[j] = sat(sum_i x[i]*W[j][i] + b[j]).
// Buffers one input vector, then per output row streams IN_DIM weights plus
// the bias from an external synchronous memory through a 3-stage MAC pipeline
// and presents the result on a valid/ready output port.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, busy, done     layer control / status (done = 1-cycle pulse)
//   in_valid/in_ready/in_data          input vector stream, x[0..IN_DIM-1]
//   w_rd_en/w_addr/w_data              weight memory, data 1 cycle after read
//   out_valid/out_ready/out_data/out_idx/out_sat   result stream
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// LOAD  | accepting x[i] into the input buffer
// MAC   | issuing IN_DIM+1 weight/bias reads for row j
// DRAIN | 2 cycles letting the MAC pipeline empty
// OUT   | holding y[j] until out_ready
module linear_fc_engine #(
    parameter int DATA_W  = 32,
    parameter int FRAC    = 24,
    parameter int IN_DIM  = 20,
    parameter int OUT_DIM = 12,
    parameter int ACC_W   = 72,
    parameter int RELU    = 0,
    parameter int WADDR_W = $clog2(OUT_DIM*(IN_DIM+1)),
    parameter int IDX_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               w_rd_en,
    output logic [WADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0]  w_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_sat
);

    localparam int CNT_W = $clog2(IN_DIM+1);
    localparam int P_W   = 2*DATA_W;
    localparam logic signed [ACC_W-1:0] MAX_A = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_A = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_OUT} state_t;
    state_t state, state_d;

    logic [CNT_W-1:0]   i_cnt, k_cnt;
    logic [IDX_W-1:0]   j_cnt;
    logic [WADDR_W-1:0] base_q;
    logic               drain_cnt;
    logic [DATA_W-1:0]  x_buf [IN_DIM];

    logic                    s1_v, s1_bias, p_v;
    logic [DATA_W-1:0]       s1_x;
    logic signed [P_W-1:0]   p_reg;
    logic signed [ACC_W-1:0] acc;

    logic last_in, last_k, last_j, mac_entry;
    assign last_in = (i_cnt == CNT_W'(IN_DIM-1));
    assign last_k  = (k_cnt == CNT_W'(IN_DIM));
    assign last_j  = (j_cnt == IDX_W'(OUT_DIM-1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d  = state;
        busy     = 1'b1;
        in_ready = 1'b0;
        w_rd_en  = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                // start in the done cycle is deliberately dropped
                if (start && !done) state_d = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_in) state_d = S_MAC;
            end
            S_MAC: begin
                w_rd_en = 1'b1;
                if (last_k) state_d = S_DRAIN;
            end
            S_DRAIN: if (drain_cnt) state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = last_j ? S_IDLE : S_MAC;
            default: state_d = S_IDLE;
        endcase
    end

    assign mac_entry = (state_d == S_MAC) && (state != S_MAC);
    assign w_addr    = base_q + WADDR_W'(k_cnt);

    // ---------------- result formation ----------------
    logic signed [ACC_W-1:0] p_ext, acc_fin, r_sh, r_rl;
    logic [DATA_W-1:0]       res_data;
    logic                    res_sat;

    always_comb begin
        p_ext   = {{(ACC_W-P_W){p_reg[P_W-1]}}, p_reg};
        // final bias term is still in the product register when DRAIN ends
        acc_fin = acc + (p_v ? p_ext : '0);
        r_sh    = acc_fin >>> FRAC;
        r_rl    = ((RELU != 0) && (r_sh < 0)) ? '0 : r_sh;
        res_sat = 1'b0;
        if (r_rl > MAX_A) begin
            res_data = {1'b0, {(DATA_W-1){1'b1}}};
            res_sat  = 1'b1;
        end else if (r_rl < MIN_A) begin
            res_data = {1'b1, {(DATA_W-1){1'b0}}};
            res_sat  = 1'b1;
        end else begin
            res_data = r_rl[DATA_W-1:0];
        end
    end

    // ---------------- control counters and output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt     <= '0;
            k_cnt     <= '0;
            j_cnt     <= '0;
            base_q    <= '0;
            drain_cnt <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_sat   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start && !done) begin
                    i_cnt  <= '0;
                    j_cnt  <= '0;
                    base_q <= '0;
                end
                S_LOAD: if (in_valid) begin
                    if (last_in) k_cnt <= '0;
                    else         i_cnt <= i_cnt + CNT_W'(1);
                end
                S_MAC: begin
                    k_cnt     <= k_cnt + CNT_W'(1);
                    drain_cnt <= 1'b0;
                end
                S_DRAIN: begin
                    drain_cnt <= ~drain_cnt;
                    if (drain_cnt) begin
                        out_valid <= 1'b1;
                        out_data  <= res_data;
                        out_idx   <= j_cnt;
                        out_sat   <= res_sat;
                    end
                end
                S_OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (last_j) begin
                        done <= 1'b1;
                    end else begin
                        j_cnt  <= j_cnt + IDX_W'(1);
                        base_q <= base_q + WADDR_W'(IN_DIM+1);
                        k_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // input buffer: contents are don't-care after reset, so no reset term
    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid) x_buf[i_cnt] <= in_data;
    end

    // ---------------- MAC pipeline ----------------
    // stage 1: x[k] travels alongside the read so it meets w_data next cycle
    // stage 2: product (or bias << FRAC) registered
    // stage 3: accumulate
    logic [CNT_W-1:0]      x_idx;
    logic signed [P_W-1:0] xa, wa, term;

    always_comb begin
        x_idx = (k_cnt < CNT_W'(IN_DIM)) ? k_cnt : '0;
        xa    = {{DATA_W{s1_x[DATA_W-1]}}, s1_x};
        wa    = {{DATA_W{w_data[DATA_W-1]}}, w_data};
        term  = s1_bias ? (wa <<< FRAC) : (xa * wa);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_bias <= 1'b0;
            s1_x    <= '0;
            p_v     <= 1'b0;
            p_reg   <= '0;
            acc     <= '0;
        end else begin
            s1_v    <= (state == S_MAC);
            s1_bias <= last_k;
            s1_x    <= x_buf[x_idx];
            p_v     <= s1_v;
            p_reg   <= s1_v ? term : '0;
            if (mac_entry) acc <= '0;
            else if (p_v)  acc <= acc + p_ext;
        end
    end

endmodule

// File: doc/linear_fc_engine.md
Name: linear_fc_engine

Overview:
Parametrised fully-connected layer engine for the KWS datapath: y[j] = sat(sum_i x[i]*W[j][i] + b[j]) for j = 0..OUT_DIM-1.
- Buffers one input vector streamed in over a valid/ready handshake.
- Reads weights and biases from an external synchronous weight memory through a 3-stage MAC pipeline.
- Streams outputs with backpressure, with optional ReLU and saturation.
- Sits between the feature/conv stages and the classifier output logic.

Parameters:
DATA_W, 32, signed fixed-point width of x, W, b and y.
FRAC, 24, fractional bits (default Q8.24).
IN_DIM, 20, input vector length.
OUT_DIM, 12, number of output neurons.
ACC_W, 72, accumulator width; must be >= 2*DATA_W + clog2(IN_DIM+1). A smaller value wraps silently and is not checked.
RELU, 0, 1 = clamp negative results to 0 before output.
WADDR_W, clog2(OUT_DIM*(IN_DIM+1)), weight memory address width.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset; asynchronous, active-low.
start  in  1  begin one layer evaluation; sampled only in IDLE.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the last output handshakes.
in_valid  in  1  input element valid.
in_ready  out  1  engine accepts input element.
in_data  in  DATA_W  input element x[i], in index order.
w_rd_en  out  1  weight memory read strobe.
w_addr  out  WADDR_W  weight address = j*(IN_DIM+1)+k; k = IN_DIM is the bias b[j].
w_data  in  DATA_W  read data, valid exactly 1 cycle after w_rd_en.
out_valid  out  1  output element valid.
out_ready  in  1  downstream accepts output.
out_data  out  DATA_W  y[j].
out_idx  out  clog2(OUT_DIM)  neuron index j of out_data.
out_sat  out  1  y[j] was saturated; qualified by out_valid.

Behaviour:
- Reset (async, any state): state = IDLE. All outputs 0, counters 0, accumulator 0, pipeline valids cleared. The x buffer contents are don't-care.
- IDLE:
  - in_ready = 0; in_valid is ignored.
  - start = 1 moves to LOAD next cycle with i = 0.
- LOAD:
  - in_ready = 1.
  - Each cycle with in_valid & in_ready writes x[i] and increments i; gaps in in_valid are allowed.
  - The beat with i = IN_DIM-1 moves to MAC with j = 0, and in_ready drops the following cycle.
- MAC, per row j:
  - Cycles 0..IN_DIM after entry: w_rd_en = 1, w_addr = j*(IN_DIM+1)+k, one read per cycle, no gaps.
  - Stage 1 (k+1): w_data captured alongside x[k].
  - Stage 2 (k+2): full-precision signed product x[k]*w registered, 2*DATA_W bits.
  - Stage 3 (k+3): product sign-extended to ACC_W and added to the accumulator.
  - For k = IN_DIM the bias term is (sign-extended b[j]) << FRAC; no multiply.
  - Accumulator is cleared on MAC entry for each row.
  - After the last read, move to DRAIN.
- DRAIN:
  - 2 cycles, w_rd_en = 0, for pipeline flush.
  - Then OUT, with out_valid registered high exactly IN_DIM+3 cycles after the row's MAC entry.
- Result formation, combinational into registered OUT outputs:
  - r = acc >>> FRAC (arithmetic shift, truncation toward -inf).
  - If RELU and r < 0, r = 0.
  - If r > 2^(DATA_W-1)-1, out_data = max and out_sat = 1. If r < -2^(DATA_W-1), out_data = min and out_sat = 1. Otherwise out_data = r[DATA_W-1:0] and out_sat = 0.
  - ReLU is applied before saturation, so a ReLU-clamped value never sets out_sat.
- OUT:
  - out_valid, out_data, out_idx and out_sat are held stable until out_ready; no reads are issued meanwhile.
  - On handshake with j < OUT_DIM-1: out_valid drops next cycle, j++, back to MAC.
  - On handshake with j = OUT_DIM-1: next cycle state = IDLE, done = 1 for one cycle, out_valid = 0.
- start while busy = 1 is ignored. start on the same cycle done pulses is ignored; it is accepted only once the engine is in IDLE.
- Outputs never go X after reset. out_data, out_idx and out_sat keep their last value when out_valid = 0.

Test Plan:
- x[i] = 1.0 (0x01000000) for all i; all W = 0.5 (0x00800000); all b = 0.
  -> 12 outputs, each 0x0A000000 (10.0), out_idx 0..11 in order, out_sat = 0, done pulses once after the 12th handshake.
- x = 0; b[j] = j*1.0.
  -> out_data = j<<24 (row 5 = 0x05000000). w_addr sequence for row 1 is 21..41.
- x = 127.0 (0x7F000000); W = 127.0 -> every output 0x7FFFFFFF with out_sat = 1. Same with W = -127.0 -> 0x80000000 with out_sat = 1.
- RELU = 1; x = 1.0; W row 0 = -0.1 (0xFFE66666); b = 0.
  -> out_data = 0, out_sat = 0. Row 1 positive -> unchanged value.
- Backpressure and gaps: in_valid toggling 1/0 during LOAD -> x captured correctly. out_ready low for 5 cycles at row 3 -> out_valid, out_data and out_idx = 3 stable, w_rd_en = 0. start pulsed while busy -> no effect.
- rst_n low for 1 cycle mid-MAC on row 6 -> outputs and busy immediately 0, state IDLE. A fresh start then produces a full correct 12-output run.
